// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiplier/divider: one shift-add or restoring-divide
// step per clock, with a registered result held until the next completion.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mag_b;
  logic               sign_res, div_zero, div_ovf;

  logic               start, iterating, iter_done;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH:0]     mag_b_in;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quotient;
  logic               mul_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign iterating = (state == MUL) || (state == DIV);
  assign iter_done = iterating && (counter == CNT_W'(WIDTH));

  // |A| fits WIDTH unsigned bits (|-2^(W-1)| = 2^(W-1)); |B| keeps the extra
  // bit so it compares directly against the (WIDTH+1)-bit partial remainder.
  assign mag_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b_in = data_operandB[WIDTH-1] ? -{1'b1, data_operandB}
                                           : {1'b0, data_operandB};

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + mag_b;
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign rem_diff  = rem_shift - mag_b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_step = acc;
    if (state == MUL) begin
      acc_step = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                        : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end else if (state == DIV) begin
      acc_step = (rem_shift >= mag_b) ? {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                      : {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  assign prod     = sign_res ? -acc : acc;
  assign quotient = sign_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign mul_exc  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ctrl_MULT)     state_next = MUL;
    else if (ctrl_DIV) state_next = DIV;
    else begin
      case (state)
        MUL, DIV: if (iter_done) state_next = DONE;
        DONE:     state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    data_resultRDY = (state == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter        <= '0;
      acc            <= '0;
      mag_b          <= '0;
      sign_res       <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      counter  <= '0;
      acc      <= {{WIDTH{1'b0}}, mag_a_in};
      mag_b    <= mag_b_in;
      sign_res <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    end else if (iter_done) begin
      if (state == MUL) begin
        data_result    <= prod[WIDTH-1:0];
        data_exception <= mul_exc;
      end else if (div_zero) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else if (div_ovf) begin
        data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
        data_exception <= 1'b1;
      end else begin
        data_result    <= quotient;
        data_exception <= 1'b0;
      end
    end else if (iterating) begin
      acc     <= acc_step;
      counter <= counter + CNT_W'(1);
    end
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiplier/divider in the processor execute stage.
- Its result, exception flag and ready pulse feed the writeback-select 8:1 mux and the stall logic.
- Takes single-cycle start pulses and iterates one bit per clock.
- Produces a registered result held stable until the next operation starts.

Parameters:
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- data_operandA  input  WIDTH  multiplicand / dividend (two's complement).
- data_operandB  input  WIDTH  multiplier / divisor (two's complement).
- ctrl_MULT  input  1  start-multiply pulse; operands sampled same edge.
- ctrl_DIV  input  1  start-divide pulse; operands sampled same edge.
- data_result  output  WIDTH  product low word or quotient.
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse: result valid.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0, operand/accumulator registers=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE -> MUL on ctrl_MULT; -> DIV on ctrl_DIV.
  - MUL/DIV -> DONE when counter reaches WIDTH.
  - DONE -> IDLE the next cycle if there is no new start.
- Start edge (any state):
  - Latch magnitudes |A|, |B|, sign_res, op type, and special-case flags.
  - counter=0, busy=1.
  - ctrl_MULT has priority if both pulses are high.
  - A start during MUL/DIV aborts the current op: no RDY for it, and the restart follows the full latency.
- Latency:
  - The start is sampled at edge E0; one iteration happens per edge E1..E32 (WIDTH iterations).
  - At E33 the result/exception registers load, state=DONE, and data_resultRDY is high for exactly one cycle after E33.
  - busy is high from after E0 through the cycle RDY is high.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*WIDTH accumulator; negate if sign_res.
  - data_result = low WIDTH bits.
  - data_exception=1 iff the signed 2*WIDTH product is not the sign extension of its low word.
  - Zero operands give result 0, exception 0.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient truncates toward zero; negate if sign_res. The remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, with the same 33-edge latency.
  - Dividend -2^(WIDTH-1) with divisor -1: data_result=0x80000000, data_exception=1.
- Magnitude of -2^(WIDTH-1) is represented in WIDTH+1 bits internally.
- Output holding:
  - data_result/data_exception hold their last values through IDLE and across later operations until that operation's completion edge.
  - A start does not clear them.
- Operand inputs are ignored except at start edges. Changing them mid-operation has no effect.

Test Plan:
- Reset, then ctrl_MULT with A=7, B=-3 -> RDY pulse 33 edges later, data_result=0xFFFFFFEB, exception=0, busy low the next cycle.
- ctrl_MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Then A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- ctrl_DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. Then A=100, B=-7 -> 0xFFFFFFF2 (-14).
- ctrl_DIV A=5, B=0 -> result=0, exception=1 at 33 edges. Then A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_MULT (6*7), then ctrl_DIV (20/4) 10 cycles later -> exactly one RDY, 33 edges after the DIV start, result=5, exception=0. The prior result is held until then.
- Assert reset during cycle 15 of a multiply -> all outputs 0 immediately, no RDY afterward. A new ctrl_MULT 3*3 after release -> 9.
